instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of tdmArbiter's instruction port. Generates sequential
//  fetch addresses, runs the reqI/memIReady handshake, buffers returned words in a small prefetch
//  FIFO, and presents {pc, instruction} to the core. Supports redirect (branch/jump) with a FIFO flush.
// PARAMETERS
//  IADDR_W     32  instruction address width (matches arbiter IADDR_W)
//  DDATA_W     32  instruction word width (matches arbiter DDATA_W)
//  FIFO_DEPTH  4   prefetch entries; power of 2, >=2
//  RESET_PC    0   first fetch address after reset
//  PC_STEP     1   address increment per fetch (memory is word addressed)
// PORTS
//  clk            in   1         system clock, all logic on posedge
//  reset          in   1         asynchronous, active-low reset
//  memIAddr       out  IADDR_W   fetch address to arbiter, registered
//  reqI           out  1         fetch request to arbiter, registered
//  memIReady      in   1         one-cycle pulse: fetch complete, memDataOutReg valid this cycle
//  memDataOutReg  in   DDATA_W   fetched word from arbiter
//  redirValid     in   1         redirect fetch stream this cycle
//  redirPc        in   IADDR_W   redirect target
//  instValid      out  1         FIFO head valid (= !empty)
//  instReady      in   1         core consumes head when instValid&&instReady
//  inst           out  DDATA_W   FIFO head instruction
//  instPc         out  IADDR_W   FIFO head address
// BEHAVIOUR
//  Reset (async, reset==0): reqI=0, memIAddr=RESET_PC, fetchPc=RESET_PC, FIFO empty, instValid=0, state IDLE.
//  FSM states IDLE, REQ, DRAIN:
//   IDLE : if FIFO count<FIFO_DEPTH -> reqI<=1, memIAddr<=fetchPc, go REQ. Else stay, reqI=0.
//   REQ  : hold reqI=1 and memIAddr stable until memIReady. On memIReady: push {memIAddr,
//          memDataOutReg}, fetchPc<=fetchPc+PC_STEP, reqI<=0, go IDLE. reqI is low >=1 cycle between requests.
//   DRAIN: outstanding request whose data must be dropped; hold reqI/memIAddr until memIReady,
//          discard data, reqI<=0, go IDLE.
//  Redirect (redirValid=1), highest priority, same edge:
//   - FIFO flushed (count=0); a concurrent pop is ignored; fetchPc<=redirPc.
//   - IDLE: next cycle IDLE with new fetchPc (request issued cycle after).
//   - REQ without memIReady: go DRAIN; request is never withdrawn mid-handshake.
//   - REQ with memIReady same cycle: returned word discarded, go IDLE.
//   - DRAIN: fetchPc<=redirPc, stay DRAIN (latest redirect wins); with memIReady -> IDLE.
//  FIFO: head outputs combinational from storage; push and pop in same cycle allowed (count unchanged).
//   Request issued only when count<FIFO_DEPTH and at most one outstanding, so overflow cannot occur.
//   memIReady outside REQ/DRAIN is ignored.
//  Arithmetic: fetchPc wraps modulo 2^IADDR_W. Latency: request asserted 1 cycle after entering IDLE
//   with space; instValid rises the cycle after the memIReady edge.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perfFetched[31:0] (words pushed into FIFO) and perfStall[31:0]
//   (cycles with instReady=1 and instValid=0); both reset to 0, wrap at 2^32, not cleared on redirect.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (with tdmArbiter + dummy memory, mem[i]=i for i=0..15)
//  1. Reset held 1 period, then instReady=1 -> reqI low in reset; instPc/inst sequence 0/0,1/1,2/2...
//  2. instReady=0 -> after 4 pushes instValid=1, inst=0, reqI stays 0 indefinitely; release -> fetch resumes at 4.
//  3. FIFO holds 2 entries, IDLE, redirPc=8 -> next cycle instValid=0; next request memIAddr=8; inst=8, instPc=8.
//  4. redirPc=3 while reqI=1 memIAddr=5 -> reqI/memIAddr=5 held to memIReady, word 5 dropped, next memIAddr=3.
//  5. redirValid coincident with memIReady (addr 6), redirPc=1 -> word 6 never appears; next inst=1.
//  6. IADDR_W=4, redirPc=15, instReady=1 -> instPc 15 then 0; with FETCH_PERF_EN perfFetched counts 2.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential address generation, reqI/memIReady
// handshake, prefetch FIFO presenting {pc, instruction}, and redirect flush.
// Optional build macro FETCH_PERF_EN adds perfFetched/perfStall counters.
module instr_fetch_unit #(
    parameter int unsigned IADDR_W    = 32,
    parameter int unsigned DDATA_W    = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned PC_STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IADDR_W-1:0] memIAddr,
    output logic               reqI,
    input  logic               memIReady,
    input  logic [DDATA_W-1:0] memDataOutReg,
    input  logic               redirValid,
    input  logic [IADDR_W-1:0] redirPc,
    output logic               instValid,
    input  logic               instReady,
    output logic [DDATA_W-1:0] inst,
    output logic [IADDR_W-1:0] instPc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perfFetched,
    output logic [31:0]        perfStall
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic               w_issue;
    logic               w_complete;
    logic               w_accept;
    logic               w_pop;
    logic               w_space;

    logic [IADDR_W-1:0] r_fetchPc;
    logic [IADDR_W-1:0] r_memIAddr;
    logic               r_reqI;

    logic [IADDR_W-1:0] r_pcMem   [FIFO_DEPTH];
    logic [DDATA_W-1:0] r_instMem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    assign w_space   = (r_count < CNT_W'(FIFO_DEPTH));
    assign instValid = (r_count != '0);
    assign inst      = r_instMem[r_rdPtr];
    assign instPc    = r_pcMem[r_rdPtr];
    assign memIAddr  = r_memIAddr;
    assign reqI      = r_reqI;
    // A redirect flushes the FIFO, so a pop on the same edge has no meaning.
    assign w_pop     = instValid && instReady && !redirValid;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake control; a redirect never withdraws a live request
    always_comb begin
        w_stateNext = r_state;
        w_issue     = 1'b0;
        w_complete  = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!redirValid && w_space) begin
                    w_issue     = 1'b1;
                    w_stateNext = S_REQ;
                end
            end
            S_REQ: begin
                if (memIReady) begin
                    w_complete  = 1'b1;
                    w_accept    = !redirValid;
                    w_stateNext = S_IDLE;
                end else if (redirValid) begin
                    w_stateNext = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (memIReady) begin
                    w_complete  = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Request outputs and fetch program counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reqI     <= 1'b0;
            r_memIAddr <= IADDR_W'(RESET_PC);
            r_fetchPc  <= IADDR_W'(RESET_PC);
        end else begin
            if (w_issue) begin
                r_reqI     <= 1'b1;
                r_memIAddr <= r_fetchPc;
            end else if (w_complete) begin
                r_reqI <= 1'b0;
            end
            if (redirValid) begin
                r_fetchPc <= redirPc;
            end else if (w_accept) begin
                r_fetchPc <= r_fetchPc + IADDR_W'(PC_STEP);
            end
        end
    end

    // FIFO pointers and occupancy; redirect flushes everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (redirValid) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            unique case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write of returned {address, word}
    always_ff @(posedge clk) begin
        if (w_accept && !redirValid) begin
            r_pcMem[r_wrPtr]   <= r_memIAddr;
            r_instMem[r_wrPtr] <= memDataOutReg;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perfFetched;
    logic [31:0] r_perfStall;

    assign perfFetched = r_perfFetched;
    assign perfStall   = r_perfStall;

    // Performance counters: words pushed, and cycles the core waited on an empty FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perfFetched <= '0;
            r_perfStall   <= '0;
        end else begin
            if (w_accept) begin
                r_perfFetched <= r_perfFetched + 32'd1;
            end
            if (instReady && !instValid) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model (queue FIFO, fetch
// pointer, outstanding-request flag) checked every cycle, plus literal pins.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memIAddr;
    logic        reqI;
    logic        memIReady;
    logic [31:0] memDataOutReg;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        instValid;
    logic        instReady;
    logic [31:0] inst;
    logic [31:0] instPc;
`ifdef FETCH_PERF_EN
    logic [31:0] perfFetched;
    logic [31:0] perfStall;
`endif

    instr_fetch_unit #(
        .IADDR_W(32), .DDATA_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(0), .PC_STEP(1)
    ) dut (
        .clk(clk), .reset(reset),
        .memIAddr(memIAddr), .reqI(reqI),
        .memIReady(memIReady), .memDataOutReg(memDataOutReg),
        .redirValid(redirValid), .redirPc(redirPc),
        .instValid(instValid), .instReady(instReady),
        .inst(inst), .instPc(instPc)
`ifdef FETCH_PERF_EN
        , .perfFetched(perfFetched), .perfStall(perfStall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: what the fetch stage must look like after each edge
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] m_next_pc = 32'd0;
    logic [31:0] m_addr    = 32'd0;
    bit          m_req     = 1'b0;
    bit          m_drop    = 1'b0;
    logic [31:0] m_fetched = 32'd0;
    logic [31:0] m_stall   = 32'd0;

    task automatic model_edge(input bit rdy_in, input logic [31:0] dat, input bit rv,
                              input logic [31:0] rpc, input bit irdy);
        bit pop;
        bit push;
        int unsigned sz;
        sz   = q_pc.size();
        pop  = (sz > 0) && irdy && !rv;
        push = 1'b0;
        if (irdy && sz == 0) m_stall++;
        if (m_req) begin
            if (rdy_in) begin
                if (!m_drop && !rv) begin
                    push = 1'b1;
                    m_next_pc++;
                    m_fetched++;
                end
                m_req  = 1'b0;
                m_drop = 1'b0;
            end else if (rv) begin
                m_drop = 1'b1;
            end
            if (rv) m_next_pc = rpc;
        end else begin
            if (rv) m_next_pc = rpc;
            else if (sz < DEPTH) begin
                m_req  = 1'b1;
                m_addr = m_next_pc;
            end
        end
        if (rv) begin
            q_pc.delete();
            q_in.delete();
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (push) begin
                q_pc.push_back(m_addr);
                q_in.push_back(dat);
            end
        end
    endtask

    bit chk_en = 1'b0;

    // Per-cycle comparison of DUT outputs against the model
    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            check("reqI", reqI, m_req);
            check("memIAddr", memIAddr, m_addr);
            check("instValid", instValid, q_pc.size() > 0);
            if (q_pc.size() > 0) begin
                check("instPc", instPc, q_pc[0]);
                check("inst", inst, q_in[0]);
            end
`ifdef FETCH_PERF_EN
            check("perfFetched", perfFetched, m_fetched);
            check("perfStall", perfStall, m_stall);
`endif
        end
    end

    // Memory responder and stimulus state
    int          lat      = 1;
    int          resp_cnt = 0;
    bit          spur     = 1'b0;
    bit          rwr      = 1'b0;
    logic [31:0] rwr_pc   = 32'd0;
    logic [31:0] log_pc[$];
    logic [31:0] log_in[$];

    // Entered at a negedge, leaves at the following negedge
    task automatic cyc(input bit irdy, input bit rv, input logic [31:0] rpc);
        bit          mr;
        logic [31:0] md;
        mr = 1'b0;
        md = 32'd0;
        if (spur && !reqI) begin
            mr = 1'b1;
            md = 32'hDEAD_BEEF;
        end else if (reqI) begin
            resp_cnt++;
            if (resp_cnt >= lat) begin
                mr       = 1'b1;
                md       = memword(memIAddr);
                resp_cnt = 0;
            end
        end
        if (rwr && mr && reqI) begin
            rv  = 1'b1;
            rpc = rwr_pc;
            rwr = 1'b0;
        end
        memIReady     = mr;
        memDataOutReg = md;
        redirValid    = rv;
        redirPc       = rpc;
        instReady     = irdy;
        if (instValid && irdy && !rv) begin
            log_pc.push_back(instPc);
            log_in.push_back(inst);
        end
        model_edge(mr, md, rv, rpc, irdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit irdy);
        for (int i = 0; i < n; i++) cyc(irdy, 1'b0, 32'd0);
    endtask

    task automatic wait_req(input logic [31:0] a, input bit irdy, input string nm);
        int n;
        n = 0;
        while (!(reqI === 1'b1 && memIAddr === a) && n < 40) begin
            cyc(irdy, 1'b0, 32'd0);
            n++;
        end
        check(nm, (reqI === 1'b1 && memIAddr === a), 1'b1);
    endtask

    task automatic check_log(input int idx, input logic [31:0] pc, input string nm);
        if (log_pc.size() > idx) begin
            check({nm, "_pc"}, log_pc[idx], pc);
            check({nm, "_inst"}, log_in[idx], memword(pc));
        end else begin
            check({nm, "_missing"}, log_pc.size(), idx + 1);
        end
    endtask

    task automatic clear_log();
        log_pc.delete();
        log_in.delete();
    endtask

    initial begin
        reset         = 1'b0;
        memIReady     = 1'b0;
        memDataOutReg = 32'd0;
        redirValid    = 1'b0;
        redirPc       = 32'd0;
        instReady     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_reqI", reqI, 1'b0);
        check("rst_memIAddr", memIAddr, 32'd0);
        check("rst_instValid", instValid, 1'b0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Core stalled: four words buffered, no further requests, stray memIReady ignored
        run(10, 1'b0);
        spur = 1'b1;
        run(3, 1'b0);
        spur = 1'b0;
        run(7, 1'b0);
        check("full_instValid", instValid, 1'b1);
        check("full_instPc", instPc, 32'd0);
        check("full_inst", inst, memword(32'd0));
        check("full_reqI", reqI, 1'b0);
        clear_log();
        run(16, 1'b1);
        for (int i = 0; i < 6; i++) check_log(i, i, "seq");

        // Redirect from IDLE with two entries buffered (concurrent pop ignored)
        cyc(1'b0, 1'b1, 32'd40);
        for (int n = 0; n < 30 && !(q_pc.size() == 2 && !m_req); n++) run(1, 1'b0);
        check("two_entries", instValid && !reqI, 1'b1);
        cyc(1'b1, 1'b1, 32'd8);
        check("redir_flush", instValid, 1'b0);
        clear_log();
        run(10, 1'b1);
        check_log(0, 32'd8, "redir8_a");
        check_log(1, 32'd9, "redir8_b");

        // Redirect mid-handshake: request held, word dropped, latest target wins
        lat = 3;
        cyc(1'b1, 1'b1, 32'd5);
        wait_req(32'd5, 1'b1, "req5");
        cyc(1'b1, 1'b1, 32'd12);
        check("drain_reqI", reqI, 1'b1);
        check("drain_addr", memIAddr, 32'd5);
        cyc(1'b1, 1'b1, 32'd3);
        clear_log();
        for (int n = 0; n < 20 && !(reqI && memIAddr != 32'd5); n++) run(1, 1'b1);
        check("after_drain_addr", memIAddr, 32'd3);
        run(12, 1'b1);
        check_log(0, 32'd3, "drain3");

        // Redirect coincident with memIReady: returned word discarded
        lat = 2;
        cyc(1'b1, 1'b1, 32'd6);
        wait_req(32'd6, 1'b1, "req6");
        rwr    = 1'b1;
        rwr_pc = 32'd1;
        clear_log();
        run(12, 1'b1);
        check_log(0, 32'd1, "coinc1");

        // Address wrap at the top of the space
        lat = 1;
        cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
        clear_log();
        run(10, 1'b1);
        check_log(0, 32'hFFFF_FFFF, "wrap_a");
        check_log(1, 32'd0, "wrap_b");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
